vinsn_dispatch: RTL

- Single-entry issue stage behind the vector instruction field decode.
- Accepts 32-bit vector instructions over a valid/ready handshake and classifies them as ALU (OP-V), memory (LOAD-FP/STORE-FP) or config (OP-V, funct3=7).
- Checks register hazards against a 32-bit vector-register scoreboard and dispatches each instruction to exactly one unit over its own valid/ready pair.
- Config instructions are serialized: they issue only after all outstanding vector writes have drained.

---
 rtl/vrvv_pkg.sv | 31 +++
 rtl/vreg_scoreboard.sv | 39 +++
 rtl/vinsn_dispatch.sv | 117 +++++++++++
 3 files changed

// File: rtl/vrvv_pkg.sv
// Shared encodings and types for the vector instruction issue stage.
// Opcode/funct3 constants, instruction classes, dispatch FSM states.
package vrvv_pkg;

    localparam logic [6:0] OPC_OPV     = 7'h57;
    localparam logic [6:0] OPC_LOADFP  = 7'h07;
    localparam logic [6:0] OPC_STOREFP = 7'h27;
    localparam logic [2:0] FUNCT3_CFG  = 3'd7;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_CFG,
        CLS_ILL
    } insn_class_t;

    typedef enum logic {
        EMPTY,
        HELD
    } disp_state_t;

    function automatic insn_class_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
        if (opcode == OPC_OPV)
            return (funct3 == FUNCT3_CFG) ? CLS_CFG : CLS_ALU;
        else if (opcode == OPC_LOADFP || opcode == OPC_STOREFP)
            return CLS_MEM;
        else
            return CLS_ILL;
    endfunction

endpackage

// File: rtl/vreg_scoreboard.sv
// Vector-register busy scoreboard: one set and one clear per cycle,
// a set wins over a clear aimed at the same register.
module vreg_scoreboard #(
    parameter int NUM_VREGS = 32,
    parameter int IDX_W     = $clog2(NUM_VREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [IDX_W-1:0]     set_idx,
    input  logic                 clr_en,
    input  logic [IDX_W-1:0]     clr_idx,
    output logic [NUM_VREGS-1:0] busy_mask
);

    logic [NUM_VREGS-1:0] busy_q;
    logic [NUM_VREGS-1:0] busy_d;

    // NOTE: combinational next-state uses blocking '=' with a default first so no latch
    // is inferred; the later set assignment overriding the clear gives set priority.
    always_comb begin
        busy_d = busy_q;
        if (clr_en)
            busy_d[clr_idx] = 1'b0;
        if (set_en)
            busy_d[set_idx] = 1'b1;
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_mask = busy_q;

endmodule

// File: rtl/vinsn_dispatch.sv
// Single-entry vector issue stage: classify the held instruction, check
// register hazards against the scoreboard and hand it to exactly one unit.
module vinsn_dispatch
    import vrvv_pkg::*;
#(
    parameter int INSN_WIDTH = 32,
    parameter int NUM_VREGS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSN_WIDTH-1:0] in_insn,
    output logic [INSN_WIDTH-1:0] out_insn,
    output logic                  alu_valid,
    input  logic                  alu_ready,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  cfg_valid,
    input  logic                  cfg_ready,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_vd,
    output logic                  illegal,
    output logic [NUM_VREGS-1:0]  busy_mask
);

    disp_state_t           state_q;
    logic [INSN_WIDTH-1:0] insn_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] vd, vs1, vs2;
    logic       vm, mop0;
    logic       held, is_load, is_store;
    insn_class_t cls;

    assign opcode   = insn_q[6:0];
    assign funct3   = insn_q[14:12];
    assign vd       = insn_q[11:7];
    assign vs1      = insn_q[19:15];
    assign vs2      = insn_q[24:20];
    assign vm       = insn_q[25];
    assign mop0     = insn_q[26];
    assign cls      = classify(opcode, funct3);
    assign is_load  = (opcode == OPC_LOADFP);
    assign is_store = (opcode == OPC_STOREFP);
    assign held     = (state_q == HELD);

    // Every register the held instruction reads or writes; vd doubles as vs3 for stores.
    logic [NUM_VREGS-1:0] use_mask;
    always_comb begin
        use_mask = '0;
        if (cls == CLS_ALU) begin
            use_mask[vs2] = 1'b1;
            use_mask[vd]  = 1'b1;
            if (funct3 <= 3'd2)
                use_mask[vs1] = 1'b1;
        end
        if (cls == CLS_MEM) begin
            use_mask[vd] = 1'b1;
            if (mop0)
                use_mask[vs2] = 1'b1;
        end
        if ((cls == CLS_ALU || cls == CLS_MEM) && !vm)
            use_mask[0] = 1'b1;
    end

    logic hazard, fire, capture, set_en;

    assign hazard    = |(use_mask & busy_mask);
    assign alu_valid = held && (cls == CLS_ALU) && !hazard;
    assign mem_valid = held && (cls == CLS_MEM) && !hazard;
    assign cfg_valid = held && (cls == CLS_CFG) && (busy_mask == '0);
    assign illegal   = held && (cls == CLS_ILL);

    assign fire     = (alu_valid && alu_ready) || (mem_valid && mem_ready) || (cfg_valid && cfg_ready);
    assign in_ready = !held || fire || illegal;
    assign capture  = in_valid && in_ready;
    assign set_en   = fire && ((cls == CLS_ALU) || (cls == CLS_MEM && is_load && !is_store));
    assign out_insn = insn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            insn_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (capture) begin
                        insn_q  <= in_insn;
                        state_q <= HELD;
                    end
                end
                HELD: begin
                    if (capture)
                        insn_q <= in_insn;
                    else if (fire || illegal)
                        state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    vreg_scoreboard #(
        .NUM_VREGS (NUM_VREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_en),
        .set_idx   (vd),
        .clr_en    (wb_valid),
        .clr_idx   (wb_vd),
        .busy_mask (busy_mask)
    );

endmodule
